// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath: fetch, decode, execute,
// memory and writeback sequencing, with stalls on the memory-ready handshake.
module mips_multicycle_ctrl #(
   parameter logic [5:0] OP_RTYPE = 6'b000000,
   parameter logic [5:0] OP_LW    = 6'b100011,
   parameter logic [5:0] OP_SW    = 6'b101011,
   parameter logic [5:0] OP_BEQ   = 6'b000100,
   parameter logic [5:0] OP_ADDI  = 6'b001000,
   parameter logic [5:0] OP_J     = 6'b000010
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_en,
   output logic       ir_write,
   output logic       mem_write,
   output logic       iord,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_src,
   output logic       illegal_op,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      EXECUTE = 4'd6,
      ALUWB   = 4'd7,
      BRANCH  = 4'd8,
      ADDIEX  = 4'd9,
      ADDIWB  = 4'd10,
      JUMP    = 4'd11
   } state_t;

   state_t state_q;
   logic   pc_write;
   logic   branch;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= FETCH;
         illegal_op <= 1'b0;
      end else begin
         illegal_op <= 1'b0;
         case (state_q)
            FETCH:   state_q <= mem_ready ? DECODE : FETCH;
            DECODE: begin
               if (op == OP_LW || op == OP_SW) state_q <= MEMADR;
               else if (op == OP_RTYPE)        state_q <= EXECUTE;
               else if (op == OP_BEQ)          state_q <= BRANCH;
               else if (op == OP_ADDI)         state_q <= ADDIEX;
               else if (op == OP_J)            state_q <= JUMP;
               else begin
                  state_q    <= FETCH;
                  illegal_op <= 1'b1;
               end
            end
            MEMADR: begin
               if (op == OP_LW)      state_q <= MEMRD;
               else if (op == OP_SW) state_q <= MEMWR;
               else                  state_q <= FETCH;
            end
            MEMRD:   state_q <= mem_ready ? MEMWB : MEMRD;
            MEMWR:   state_q <= mem_ready ? FETCH : MEMWR;
            EXECUTE: state_q <= ALUWB;
            ADDIEX:  state_q <= ADDIWB;
            default: state_q <= FETCH;
         endcase
      end
   end

   assign state = state_q;

   always_comb begin
      pc_write   = 1'b0;
      branch     = 1'b0;
      ir_write   = 1'b0;
      mem_write  = 1'b0;
      iord       = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      pc_src     = 2'b00;
      case (state_q)
         FETCH: begin
            // PC+4 and IR load only commit once the instruction word arrives
            alu_src_b = 2'b01;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         DECODE:  alu_src_b = 2'b11;
         MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         MEMRD:   iord = 1'b1;
         MEMWB: begin
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
         end
         MEMWR: begin
            iord      = 1'b1;
            mem_write = 1'b1;
         end
         EXECUTE: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
         end
         ALUWB: begin
            reg_dst   = 1'b1;
            reg_write = 1'b1;
         end
         BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b01;
            pc_src    = 2'b01;
            branch    = 1'b1;
         end
         ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         ADDIWB:  reg_write = 1'b1;
         JUMP: begin
            pc_src   = 2'b10;
            pc_write = 1'b1;
         end
         default: ;
      endcase
   end

   assign pc_en = pc_write | (branch & zero);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized bench: each instruction is expanded into a cycle-by-cycle plan of
// expected states and control words, then driven and compared every cycle.
module tb_mips_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] op = 6'd0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b1;
   logic       pc_en, ir_write, mem_write, iord, reg_write, reg_dst, mem_to_reg;
   logic       alu_src_a, illegal_op;
   logic [1:0] alu_src_b, alu_op, pc_src;
   logic [3:0] state;

   int errors = 0;
   int checks = 0;
   bit ill_pending = 1'b0;
   logic [14:0] tbl [16];

   mips_multicycle_ctrl dut (
      .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
      .pc_en(pc_en), .ir_write(ir_write), .mem_write(mem_write), .iord(iord),
      .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .pc_src(pc_src), .illegal_op(illegal_op), .state(state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [14:0] ctl_word();
      return {pc_en, ir_write, mem_write, iord, reg_write, reg_dst, mem_to_reg,
              alu_src_a, alu_src_b, alu_op, pc_src, illegal_op};
   endfunction

   // Expected word for one cycle from the per-step table plus handshake/flag gating.
   function automatic logic [14:0] exp_word(int st, bit mr, bit z, bit ill);
      logic [14:0] w;
      w = tbl[st];
      if (st == 0 && !mr) w[14:13] = 2'b00;
      if (st == 8 && z)   w[14] = 1'b1;
      w[0] = ill;
      return w;
   endfunction

   function automatic bit is_legal(logic [5:0] o);
      return o == 6'b000000 || o == 6'b100011 || o == 6'b101011 ||
             o == 6'b000100 || o == 6'b001000 || o == 6'b000010;
   endfunction

   // Called at posedge+1 with the DUT in FETCH; returns at posedge+1 back in FETCH.
   task automatic run_instr(input logic [5:0] o, input int fstall, input int mstall, input bit z);
      int qs[$];
      bit qm[$];
      for (int i = 0; i < fstall; i++) begin qs.push_back(0); qm.push_back(0); end
      qs.push_back(0); qm.push_back(1);
      qs.push_back(1); qm.push_back(1'($urandom));
      case (o)
         6'b100011: begin
            qs.push_back(2); qm.push_back(1'($urandom));
            for (int i = 0; i < mstall; i++) begin qs.push_back(3); qm.push_back(0); end
            qs.push_back(3); qm.push_back(1);
            qs.push_back(4); qm.push_back(1'($urandom));
         end
         6'b101011: begin
            qs.push_back(2); qm.push_back(1'($urandom));
            for (int i = 0; i < mstall; i++) begin qs.push_back(5); qm.push_back(0); end
            qs.push_back(5); qm.push_back(1);
         end
         6'b000000: begin qs.push_back(6); qm.push_back(1); qs.push_back(7); qm.push_back(1); end
         6'b001000: begin qs.push_back(9); qm.push_back(1); qs.push_back(10); qm.push_back(1); end
         6'b000100: begin qs.push_back(8); qm.push_back(1'($urandom)); end
         6'b000010: begin qs.push_back(11); qm.push_back(1'($urandom)); end
         default: ;
      endcase
      op = o;
      zero = z;
      for (int c = 0; c < qs.size(); c++) begin
         mem_ready = qm[c];
         @(negedge clk);
         chk($sformatf("state op=%b c=%0d", o, c), 32'(state), 32'(qs[c]));
         chk($sformatf("ctl op=%b st=%0d", o, qs[c]), 32'(ctl_word()),
             32'(exp_word(qs[c], qm[c], z, ill_pending && c == 0)));
         chk("one_write", 32'($onehot0({reg_write, mem_write, ir_write})), 32'd1);
         @(posedge clk);
         #1;
      end
      ill_pending = !is_legal(o);
   endtask

   initial begin
      logic [5:0] ops [6];
      logic [5:0] o;
      tbl = '{default: 15'd0};
      tbl[0]  = 15'b110000000100000;
      tbl[1]  = 15'b000000001100000;
      tbl[2]  = 15'b000000011000000;
      tbl[3]  = 15'b000100000000000;
      tbl[4]  = 15'b000010100000000;
      tbl[5]  = 15'b001100000000000;
      tbl[6]  = 15'b000000010010000;
      tbl[7]  = 15'b000011000000000;
      tbl[8]  = 15'b000000010001010;
      tbl[9]  = 15'b000000011000000;
      tbl[10] = 15'b000010000000000;
      tbl[11] = 15'b100000000000100;
      ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};

      #2 reset = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("rst_state", 32'(state), 32'd0);
         chk("rst_illegal", 32'(illegal_op), 32'd0);
      end
      @(posedge clk);
      #1 reset = 1'b1;

      run_instr(6'b100011, 0, 0, 1'b0);
      run_instr(6'b101011, 0, 2, 1'b0);
      run_instr(6'b000100, 0, 0, 1'b1);
      run_instr(6'b000100, 1, 0, 1'b0);
      run_instr(6'b111111, 0, 0, 1'b0);
      run_instr(6'b000000, 1, 0, 1'b0);
      run_instr(6'b001000, 0, 0, 1'b0);
      run_instr(6'b000010, 0, 0, 1'b1);

      // Asynchronous reset while a load is stalled in MEMRD
      op = 6'b100011;
      mem_ready = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      mem_ready = 1'b0;
      @(negedge clk);
      chk("memrd_reached", 32'(state), 32'd3);
      #2 reset = 1'b0;
      #1;
      chk("async_rst_state", 32'(state), 32'd0);
      chk("async_rst_regw", 32'(reg_write), 32'd0);
      @(posedge clk);
      #1;
      chk("rst_hold_state", 32'(state), 32'd0);
      chk("rst_hold_regw", 32'(reg_write), 32'd0);
      reset = 1'b1;
      ill_pending = 1'b0;

      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 7) == 0) begin
            do o = 6'($urandom_range(0, 63)); while (is_legal(o));
         end else begin
            o = ops[$urandom_range(0, 5)];
         end
         run_instr(o, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
